// File: rtl/fir_cfg_pkg.sv
// Shared types and constants for the FIR coefficient loader: FSM states,
// the default lowpass half-set and the unique-coefficient count helper.
package fir_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FULL  = 2'd2,
    ERROR = 2'd3
  } state_t;

  // Default 13-tap lowpass half-set, index 6 is the centre tap (Q1.15).
  localparam logic signed [15:0] DEFAULT_COEFF [7] = '{
    16'sd6375, 16'sd1, -16'sd3656, 16'sd3, 16'sd4171, 16'sd4, 16'sd28404
  };

  function automatic int num_unique(input int taps);
    return (taps + 1) / 2;
  endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Host-side configuration handshake for the FIR coefficient loader:
// valid/ready word stream plus abort and commit controls.
interface fir_coeff_loader_if #(
  parameter int COEFF_W = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [COEFF_W-1:0] cfg_data;
  logic               cfg_last;
  logic               cfg_abort;
  logic               commit_req;

  modport master (
    output cfg_valid, cfg_data, cfg_last, cfg_abort, commit_req,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_last, cfg_abort, commit_req,
    output cfg_ready
  );
endinterface

// File: rtl/fir_coeff_bank.sv
// NUM x W coefficient register bank with one indexed write port, a whole-bank
// parallel load and a flat parallel read bus; optional synchronous reset value.
module fir_coeff_bank #(
  parameter int NUM       = 7,
  parameter int W         = 16,
  parameter int IDX_W     = 3,
  parameter bit HAS_RESET = 1'b0
) (
  input  logic               clk,
  input  logic               srst,
  input  logic [NUM*W-1:0]   rst_data,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [W-1:0]       wr_data,
  input  logic               bulk_en,
  input  logic [NUM*W-1:0]   bulk_data,
  output logic [NUM*W-1:0]   rd_data
);

  for (genvar gi = 0; gi < NUM; gi++) begin : g_word
    logic [W-1:0] word_q;

    // Bulk load wins over the indexed port so a commit is always all-or-nothing.
    always_ff @(posedge clk) begin
      if (HAS_RESET && srst) begin
        word_q <= rst_data[gi*W +: W];
      end else if (bulk_en) begin
        word_q <= bulk_data[gi*W +: W];
      end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
        word_q <= wr_data;
      end
    end

    assign rd_data[gi*W +: W] = word_q;
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// Shadow/active coefficient loader for the symmetric FIR. Define
// FIR_COEFF_DEFAULT_EN to reset the active bank to the built-in lowpass set.
module fir_coeff_loader
  import fir_cfg_pkg::*;
#(
  parameter int TAP_NUM = 13,
  parameter int COEFF_W = 16
) (
  input  logic                                       sample_clock,
  input  logic                                       reset,
  fir_coeff_loader_if.slave                          cfg,
  output logic [num_unique(TAP_NUM)*COEFF_W-1:0]     coeff_active,
  output logic                                       coeff_update,
  output logic                                       busy,
  output logic                                       load_error,
  output logic [$clog2(num_unique(TAP_NUM)+1)-1:0]   load_count
);

  localparam int NUM_UNIQUE = num_unique(TAP_NUM);
  localparam int CNT_W      = $clog2(NUM_UNIQUE + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_UNIQUE - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              upd_q, upd_d;
  logic              shadow_wr;
  logic              commit;
  logic              xfer;
  logic [NUM_UNIQUE*COEFF_W-1:0] shadow_data;
  logic [NUM_UNIQUE*COEFF_W-1:0] reset_coeff;

`ifdef FIR_COEFF_DEFAULT_EN
  if (TAP_NUM != 13) begin : g_bad_taps
    $error("FIR_COEFF_DEFAULT_EN requires TAP_NUM = 13");
    assign reset_coeff = '0;
  end else begin : g_default
    for (genvar gi = 0; gi < NUM_UNIQUE; gi++) begin : g_word
      assign reset_coeff[gi*COEFF_W +: COEFF_W] = COEFF_W'(DEFAULT_COEFF[gi]);
    end
  end
`else
  assign reset_coeff = '0;
`endif

  // Ready depends only on state and abort, so the host may gate valid on it.
  assign cfg.cfg_ready = ((state_q == IDLE) || (state_q == LOAD)) && !cfg.cfg_abort;
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    upd_d     = 1'b0;
    shadow_wr = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          shadow_wr = 1'b1;
          cnt_d     = CNT_W'(1);
          state_d   = cfg.cfg_last ? ERROR : LOAD;
        end
      end
      LOAD: begin
        if (cfg.cfg_abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (xfer) begin
          shadow_wr = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = cfg.cfg_last ? FULL : ERROR;
          end else if (cfg.cfg_last) begin
            state_d = ERROR;
          end
        end
      end
      FULL: begin
        if (cfg.cfg_abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cfg.commit_req) begin
          commit  = 1'b1;
          upd_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      ERROR: begin
        if (cfg.cfg_abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sample_clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
    end
  end

  fir_coeff_bank #(
    .NUM       (NUM_UNIQUE),
    .W         (COEFF_W),
    .IDX_W     (CNT_W),
    .HAS_RESET (1'b0)
  ) u_shadow (
    .clk       (sample_clock),
    .srst      (reset),
    .rst_data  ('0),
    .wr_en     (shadow_wr),
    .wr_idx    (cnt_q),
    .wr_data   (cfg.cfg_data),
    .bulk_en   (1'b0),
    .bulk_data ('0),
    .rd_data   (shadow_data)
  );

  fir_coeff_bank #(
    .NUM       (NUM_UNIQUE),
    .W         (COEFF_W),
    .IDX_W     (CNT_W),
    .HAS_RESET (1'b1)
  ) u_active (
    .clk       (sample_clock),
    .srst      (reset),
    .rst_data  (reset_coeff),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .bulk_en   (commit),
    .bulk_data (shadow_data),
    .rd_data   (coeff_active)
  );

  assign coeff_update = upd_q;
  assign busy         = (state_q != IDLE);
  assign load_error   = (state_q == ERROR);
  assign load_count   = cnt_q;

endmodule
